// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: a small byte FIFO in front of a start/data/stop
// serialiser, so upstream can burst bytes while the line drains at baud rate.
module uart_tx_buf #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_vld,
   output logic       rdy,
   output logic       tx,
   output logic       busy,
   output logic       ovf
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int PW       = $clog2(FIFO_DEPTH);
   localparam int CW       = PW + 1;
   localparam logic [BW-1:0] BCNT_LAST = BW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [2:0]      bidx_q, bidx_d;
   logic [7:0]      sh_q, sh_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            tx_q, tx_d;
   logic            ovf_q, ovf_d;
   logic [7:0]      mem_q [FIFO_DEPTH];

   logic            wr_en;
   logic            pop;
   logic            fifo_empty;
   logic            bit_end;

   assign rdy        = (count_q < CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign wr_en      = din_vld && rdy;
   assign bit_end    = (bcnt_q == BCNT_LAST);
   assign tx         = tx_q;
   assign busy       = (state_q != IDLE) || !fifo_empty;
   assign ovf        = ovf_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         bcnt_q   <= '0;
         bidx_q   <= '0;
         sh_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         tx_q     <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         bidx_q   <= bidx_d;
         sh_q     <= sh_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         tx_q     <= tx_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; validity is tracked by count_q.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
      ovf_d    = ovf_q | (din_vld & ~rdy);
   end

   // Next-state logic; STOP chains straight into START when more data waits.
   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      bidx_d  = bidx_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               sh_d    = mem_q[rd_ptr_q];
               bcnt_d  = '0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               bcnt_d  = '0;
               bidx_d  = '0;
               state_d = DATA;
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               bcnt_d = '0;
               sh_d   = {1'b0, sh_q[7:1]};
               if (bidx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               bcnt_d = '0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  sh_d    = mem_q[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               bcnt_d = bcnt_q + BW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is computed from the next state so tx_q changes with the state.
   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: a line monitor decodes frames and compares
// them against bytes queued by the stimulus; a second instance runs at default baud.
module tb_uart_tx_buf;

   localparam int DIV     = 10;
   localparam int DEF_DIV = 434;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din = 8'h00;
   logic       din_vld = 1'b0;
   logic       rdy, tx, busy, ovf;
   logic [7:0] din_def = 8'h00;
   logic       vld_def = 1'b0;
   logic       rdy_def, tx_def, busy_def, ovf_def;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   logic [7:0] exp_q[$];
   int         starts_q[$];

   uart_tx_buf #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
      .rdy(rdy), .tx(tx), .busy(busy), .ovf(ovf)
   );

   uart_tx_buf dut_def (
      .clk(clk), .rst(rst), .din(din_def), .din_vld(vld_def),
      .rdy(rdy_def), .tx(tx_def), .busy(busy_def), .ovf(ovf_def)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, budget);
      end
   endtask

   // Line monitor: samples every clock of a frame, demands each bit be stable.
   initial begin : monitor
      logic [9:0] bits;
      logic       stable, aborted, lv;
      lv = 1'b1;
      forever begin
         @(negedge clk);
         if (rst === 1'b0 && tx === 1'b0) begin
            starts_q.push_back(cyc);
            bits    = '0;
            stable  = 1'b1;
            aborted = 1'b0;
            for (int b = 0; b < 10 && !aborted; b++) begin
               for (int c = 0; c < DIV && !aborted; c++) begin
                  if (rst === 1'b1) aborted = 1'b1;
                  else if (c == 0) lv = tx;
                  else if (tx !== lv) stable = 1'b0;
                  if (!(b == 9 && c == DIV - 1) && !aborted) @(negedge clk);
               end
               bits[b] = lv;
            end
            if (!aborted) begin
               check("frame_format", {29'd0, stable, bits[9], bits[0]}, 32'b110);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL frame_unexpected: got 0x%0h, expected no frame", bits[8:1]);
               end else begin
                  check("frame_data", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
               end
               $display("frame 0x%0h started at cycle %0d", bits[8:1], starts_q[$]);
            end
         end
      end
   end

   initial begin : stim
      int   sz;
      logic lv;
      int   n;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_rdy", rdy, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;

      // Single byte A5: line 0,1,0,1,0,0,1,0,1,1
      @(negedge clk);
      starts_q.delete();
      exp_q.push_back(8'hA5);
      din = 8'hA5;
      din_vld = 1'b1;
      @(negedge clk);
      din_vld = 1'b0;
      check("single_tx_edge_k", tx, 1);
      @(negedge clk);
      check("single_tx_edge_k1", tx, 0);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("single_busy_len", n, 100);
      check("single_frames", starts_q.size(), 1);
      check("single_sb_empty", exp_q.size(), 0);

      // Burst 01..04: back-to-back frames
      @(negedge clk);
      starts_q.delete();
      for (int i = 1; i <= 4; i++) begin
         din = 8'(i);
         din_vld = 1'b1;
         exp_q.push_back(8'(i));
         @(negedge clk);
         check("burst_rdy", rdy, 1);
      end
      din_vld = 1'b0;
      wait_idle(1000);
      check("burst_frames", starts_q.size(), 4);
      if (starts_q.size() == 4) begin
         for (int i = 1; i < 4; i++) check("burst_gap", starts_q[i] - starts_q[i-1], 100);
         check("burst_total", cyc - starts_q[0], 400);
      end
      check("burst_sb_empty", exp_q.size(), 0);

      // Overflow: 10..15, sixth byte dropped
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         din = 8'h10 + 8'(i);
         din_vld = 1'b1;
         if (i < 5) exp_q.push_back(8'h10 + 8'(i));
         @(negedge clk);
         check("ovf_rdy", rdy, (i < 4) ? 1 : 0);
         check("ovf_flag", ovf, (i < 5) ? 0 : 1);
      end
      din_vld = 1'b0;
      wait_idle(2000);
      check("ovf_sticky", ovf, 1);
      check("ovf_sb_empty", exp_q.size(), 0);

      // Reset during data bit 3 of FF with two bytes queued
      @(negedge clk);
      starts_q.delete();
      din_vld = 1'b1;
      din = 8'hFF; exp_q.push_back(8'hFF); @(negedge clk);
      din = 8'h11; exp_q.push_back(8'h11); @(negedge clk);
      din = 8'h22; exp_q.push_back(8'h22); @(negedge clk);
      din_vld = 1'b0;
      repeat (43) @(negedge clk);
      check("mid_busy_before", busy, 1);
      sz = starts_q.size();
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      check("mid_tx", tx, 1);
      check("mid_busy", busy, 0);
      check("mid_ovf", ovf, 0);
      check("mid_rdy", rdy, 1);
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      check("mid_no_frames", starts_q.size(), sz);
      check("mid_busy_after", busy, 0);
      check("mid_tx_after", tx, 1);

      // Default parameters: 55 gives alternating line, every bit 434 clocks
      @(negedge clk);
      din_def = 8'h55;
      vld_def = 1'b1;
      @(negedge clk);
      vld_def = 1'b0;
      @(negedge clk);
      check("def_tx_start", tx_def, 0);
      for (int r = 0; r < 9; r++) begin
         lv = tx_def;
         check("def_bit_lvl", lv, r % 2);
         n = 0;
         while (tx_def === lv && n < 1000) begin
            @(negedge clk);
            n++;
         end
         check("def_bit_len", n, DEF_DIV);
      end
      n = 0;
      while (busy_def === 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("def_stop_len", n, DEF_DIV);
      check("def_tx_idle", tx_def, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: bench still running at cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
